// File: rtl/mem_port_arbiter.sv
// Byte-wide memory bus arbiter: MEM has fixed priority over IF. Each access is
// split into per-byte bus cycles, and read bytes are assembled little-endian.
module mem_port_arbiter #(
  parameter int INSTR_BYTES = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic [1:0]        mem_re_i,
  input  logic              mem_rsign_i,
  input  logic [1:0]        mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  output logic              bus_wr_o,
  input  logic [7:0]        bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [2:0]        n_q;
  logic [ADDR_W-1:0] base_q;
  logic              wr_q;
  logic              sign_q;
  logic              own_if_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       load_ext;
  logic [1:0]        byte_sel;
  logic              mem_req;
  logic [1:0]        size_sel;
  logic [2:0]        size_n;
  logic              flush_if;

  // A store wins over a load when both sizes are non-zero.
  always_comb begin
    mem_req  = (mem_re_i != 2'b00) || (mem_we_i != 2'b00);
    size_sel = (mem_we_i != 2'b00) ? mem_we_i : mem_re_i;
    case (size_sel)
      2'b01:   size_n = 3'd1;
      2'b10:   size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  end

  // Read data for the address driven at cnt-1 arrives during cycle cnt.
  always_comb begin
    asm_d    = asm_q;
    byte_sel = cnt_q[1:0] - 2'd1;
    if (state_q == XFER && !wr_q && cnt_q != 3'd0)
      asm_d[{byte_sel, 3'b000} +: 8] = bus_rdata_i;
    case (n_q)
      3'd1:    load_ext = {{24{sign_q & asm_d[7]}}, asm_d[7:0]};
      3'd2:    load_ext = {{16{sign_q & asm_d[15]}}, asm_d[15:0]};
      default: load_ext = asm_d;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    if_done_o   = 1'b0;
    mem_done_o  = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = 8'h00;
    bus_wr_o    = 1'b0;
    flush_if    = if_flush_i & own_if_q;
    case (state_q)
      IDLE: begin
        if (mem_req || (if_req_i && !if_flush_i)) state_d = XFER;
      end
      XFER: begin
        if (cnt_q < n_q) begin
          bus_addr_o  = base_q + ADDR_W'(cnt_q);
          bus_wr_o    = wr_q;
          bus_wdata_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
        if (wr_q ? (cnt_q == n_q - 3'd1) : (cnt_q == n_q)) state_d = DONE;
        if (flush_if) state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
        if (own_if_q) if_done_o  = !if_flush_i;
        else          mem_done_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      wr_q        <= 1'b0;
      sign_q      <= 1'b0;
      own_if_q    <= 1'b0;
      wdata_q     <= 32'h0;
      // NOTE: the data registers are reset as well because their values are visible on the outputs.
      asm_q       <= 32'h0;
      if_data_o   <= 32'h0;
      mem_rdata_o <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= 3'd0;
          asm_q <= 32'h0;
          if (mem_req) begin
            base_q   <= mem_addr_i;
            n_q      <= size_n;
            wr_q     <= (mem_we_i != 2'b00);
            wdata_q  <= mem_wdata_i;
            sign_q   <= mem_rsign_i;
            own_if_q <= 1'b0;
          end else if (if_req_i && !if_flush_i) begin
            base_q   <= if_addr_i;
            n_q      <= 3'(INSTR_BYTES);
            wr_q     <= 1'b0;
            wdata_q  <= 32'h0;
            sign_q   <= 1'b0;
            own_if_q <= 1'b1;
          end
        end
        XFER: begin
          cnt_q <= cnt_q + 3'd1;
          asm_q <= asm_d;
          // Results are registered on entry to DONE and then held until the next one.
          if (state_d == DONE) begin
            if (own_if_q) if_data_o   <= asm_d;
            else          mem_rdata_o <= wr_q ? 32'h0 : load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
